// File: rtl/gpio_debounce_if.sv
// rtl/gpio_debounce_if.sv - pad, configuration and conditioned-level bundle for gpio_debounce
// Master drives pads and CSR configuration; slave is the debounce stage.
interface gpio_debounce_if #(
   parameter int WIDTH = 256,
   parameter int CNT_W = 8,
   parameter int DIV_W = 16
);
   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] debounce_en;
   logic [CNT_W-1:0] threshold;
   logic [DIV_W-1:0] prescale_div;
   logic [WIDTH-1:0] gpio_out;
   logic [WIDTH-1:0] change_pulse;

   modport master (
      output pad_in,
      output debounce_en,
      output threshold,
      output prescale_div,
      input  gpio_out,
      input  change_pulse
   );

   modport slave (
      input  pad_in,
      input  debounce_en,
      input  threshold,
      input  prescale_div,
      output gpio_out,
      output change_pulse
   );
endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin synchroniser and tick-driven glitch filter for GPIO inputs
// Each enabled pin accepts a new level only after threshold+1 consecutive disagreeing ticks.
module gpio_debounce #(
   parameter int WIDTH = 256,
   parameter int CNT_W = 8,
   parameter int DIV_W = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   gpio_debounce_if.slave bus
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_gpio_out;
   logic [WIDTH-1:0] r_change_pulse;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [DIV_W-1:0] r_pcnt;

   logic [WIDTH-1:0] w_gpio_out_next;
   logic [CNT_W-1:0] w_cnt_next [WIDTH];
   logic             w_tick;

   // >= rather than == so a lowered divider ticks next cycle instead of wrapping.
   assign w_tick = (r_pcnt >= bus.prescale_div);

   always_comb begin
      w_gpio_out_next = r_gpio_out;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_next[i] = '0;
         if (!bus.debounce_en[i]) begin
            w_gpio_out_next[i] = r_sync2[i];
         end else if (r_sync2[i] != r_gpio_out[i]) begin
            if (!w_tick) begin
               w_cnt_next[i] = r_cnt[i];
            end else if (r_cnt[i] >= bus.threshold) begin
               w_gpio_out_next[i] = r_sync2[i];
            end else begin
               w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1        <= '0;
         r_sync2        <= '0;
         r_gpio_out     <= '0;
         r_change_pulse <= '0;
         r_cnt          <= '{default: '0};
         r_pcnt         <= '0;
      end else begin
         r_sync1        <= bus.pad_in;
         r_sync2        <= r_sync1;
         r_gpio_out     <= w_gpio_out_next;
         r_change_pulse <= w_gpio_out_next ^ r_gpio_out;
         r_cnt          <= w_cnt_next;
         r_pcnt         <= w_tick ? '0 : r_pcnt + DIV_W'(1);
      end
   end

   assign bus.gpio_out     = r_gpio_out;
   assign bus.change_pulse = r_change_pulse;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - scoreboard bench for gpio_debounce with directed latency cases and random traffic
module tb_gpio_debounce;
   localparam int W = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gpio_debounce_if #(.WIDTH(W), .CNT_W(8), .DIV_W(16)) bus ();

   gpio_debounce #(.WIDTH(W), .CNT_W(8), .DIV_W(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] out;
      logic [W-1:0] pul;
   } exp_t;

   typedef struct {
      string name;
      int    act;
      int    lo;
      int    hi;
   } dchk_t;

   exp_t  sq[$];
   dchk_t dq[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   // Tracked pins for latency/pulse bookkeeping: 0, 5, 200.
   int trk [3] = '{0, 5, 200};
   int rise_cnt  [3] = '{0, 0, 0};
   int rise_cyc  [3] = '{0, 0, 0};
   int pulse_cnt [3] = '{0, 0, 0};

   // Staged stimulus, applied at the next falling edge.
   logic         s_rst;
   logic [W-1:0] s_pad;
   logic [W-1:0] s_en;
   logic [7:0]   s_thr;
   logic [15:0]  s_div;
   int           applied;

   // Reference: a pin adopts the synchronised level once it has disagreed with
   // the output for threshold+1 ticks in a row; any agreement forgets the run.
   logic [W-1:0] m_s1, m_s2, m_out;
   int           m_since_tick;
   int           m_run [W];

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_out = '0;
      m_since_tick = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   task automatic cycle();
      exp_t         e;
      logic [W-1:0] nxt;
      logic         tick;
      @(negedge clk);
      rst              = s_rst;
      bus.pad_in       = s_pad;
      bus.debounce_en  = s_en;
      bus.threshold    = s_thr;
      bus.prescale_div = s_div;
      applied = cyc;
      if (s_rst) begin
         model_reset();
         e.out = '0;
         e.pul = '0;
      end else begin
         tick = (m_since_tick >= int'(s_div));
         m_since_tick = tick ? 0 : m_since_tick + 1;
         nxt = m_out;
         for (int i = 0; i < W; i++) begin
            if (!s_en[i]) begin
               nxt[i] = m_s2[i];
               m_run[i] = 0;
            end else if (m_s2[i] == m_out[i]) begin
               m_run[i] = 0;
            end else if (tick) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] > int'(s_thr)) begin
                  nxt[i] = m_s2[i];
                  m_run[i] = 0;
               end
            end
         end
         e.out = nxt;
         e.pul = nxt ^ m_out;
         m_out = nxt;
         m_s2 = m_s1;
         m_s1 = s_pad;
      end
      sq.push_back(e);
   endtask

   task automatic dpush(input string name, input int act, input int lo, input int hi);
      dchk_t d;
      d.name = name;
      d.act  = act;
      d.lo   = lo;
      d.hi   = hi;
      dq.push_back(d);
   endtask

   // Monitor: owns all comparisons and counters.
   initial begin
      logic [2:0] prev = '0;
      exp_t  e;
      dchk_t d;
      logic  b;
      forever begin
         @(posedge clk);
         #1;
         if (sq.size() > 0) begin
            e = sq.pop_front();
            n_chk++;
            if (bus.gpio_out === e.out) n_pass++;
            else $display("FAIL gpio_out cyc=%0d got %h want %h", cyc, bus.gpio_out, e.out);
            n_chk++;
            if (bus.change_pulse === e.pul) n_pass++;
            else $display("FAIL change_pulse cyc=%0d got %h want %h", cyc, bus.change_pulse, e.pul);
            for (int k = 0; k < 3; k++) begin
               b = bus.gpio_out[trk[k]];
               if (b === 1'b1 && prev[k] == 1'b0) begin
                  rise_cnt[k] = rise_cnt[k] + 1;
                  rise_cyc[k] = cyc;
               end
               if (bus.change_pulse[trk[k]] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
               prev[k] = (b === 1'b1);
            end
         end
         while (dq.size() > 0) begin
            d = dq.pop_front();
            n_chk++;
            if (d.act >= d.lo && d.act <= d.hi) n_pass++;
            else $display("FAIL %s got %0d want %0d..%0d", d.name, d.act, d.lo, d.hi);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int c_last, e0, rc, pc, rst_c;
      logic [W-1:0] flip;
      model_reset();
      s_rst = 1'b1;
      s_pad = '1;
      s_en  = '0;
      s_thr = 8'd0;
      s_div = 16'd0;

      // Reset with pads high, then bypass release.
      repeat (4) cycle();
      c_last = applied;
      dpush("reset_no_rise", rise_cnt[0], 0, 0);
      s_rst = 1'b0;
      repeat (6) cycle();
      dpush("reset_release_lat", rise_cyc[0] - c_last, 4, 4);
      dpush("reset_release_pulses", pulse_cnt[0], 1, 1);

      // Bypass latency on pin 0.
      s_pad[0] = 1'b0;
      repeat (5) cycle();
      pc = pulse_cnt[0];
      s_pad[0] = 1'b1;
      cycle();
      e0 = applied;
      repeat (6) cycle();
      dpush("bypass_lat", rise_cyc[0] - e0, 3, 3);
      dpush("bypass_pulse", pulse_cnt[0] - pc, 1, 1);

      // Stable accept on pin 5, threshold 3, no prescale.
      s_pad[5] = 1'b0;
      repeat (5) cycle();
      s_en[5] = 1'b1;
      s_thr = 8'd3;
      s_div = 16'd0;
      repeat (2) cycle();
      pc = pulse_cnt[1];
      s_pad[5] = 1'b1;
      cycle();
      e0 = applied;
      repeat (10) cycle();
      dpush("accept_lat", rise_cyc[1] - e0, 6, 6);
      dpush("accept_pulse", pulse_cnt[1] - pc, 1, 1);

      // Glitch of exactly threshold ticks is rejected.
      s_pad[5] = 1'b0;
      repeat (10) cycle();
      rc = rise_cnt[1];
      pc = pulse_cnt[1];
      s_pad[5] = 1'b1;
      repeat (3) cycle();
      s_pad[5] = 1'b0;
      repeat (12) cycle();
      dpush("glitch_rises", rise_cnt[1] - rc, 0, 0);
      dpush("glitch_pulses", pulse_cnt[1] - pc, 0, 0);

      // One tick longer is accepted.
      rc = rise_cnt[1];
      s_pad[5] = 1'b1;
      repeat (4) cycle();
      s_pad[5] = 1'b0;
      repeat (12) cycle();
      dpush("edge_accept_rises", rise_cnt[1] - rc, 1, 1);

      // Prescaled accept on pin 200.
      s_en[200] = 1'b1;
      s_thr = 8'd1;
      s_div = 16'd9;
      s_pad[200] = 1'b0;
      repeat (30) cycle();
      rc = rise_cnt[2];
      s_pad[200] = 1'b1;
      cycle();
      e0 = applied;
      repeat (30) cycle();
      dpush("prescale_lat", rise_cyc[2] - e0, 12, 22);
      dpush("prescale_rises", rise_cnt[2] - rc, 1, 1);

      // Reset mid-count discards progress.
      s_thr = 8'd200;
      s_div = 16'd0;
      rc = rise_cnt[1];
      s_pad[5] = 1'b1;
      repeat (152) cycle();
      dpush("midrst_no_early_rise", rise_cnt[1] - rc, 0, 0);
      s_rst = 1'b1;
      cycle();
      rst_c = applied;
      s_rst = 1'b0;
      repeat (210) cycle();
      dpush("midrst_lat", rise_cyc[1] - rst_c, 204, 204);
      dpush("midrst_rises", rise_cnt[1] - rc, 1, 1);

      // Random traffic with configuration changes and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            for (int w = 0; w < 8; w++) s_en[w*32 +: 32] = $urandom;
            s_thr = 8'($urandom_range(0, 4));
            s_div = 16'($urandom_range(0, 3));
         end
         if ((n / 40) % 2 == 0) begin
            for (int w = 0; w < 8; w++) flip[w*32 +: 32] = $urandom & $urandom & $urandom;
         end else begin
            flip = '0;
         end
         s_pad = s_pad ^ flip;
         s_rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      s_rst = 1'b0;
      repeat (5) cycle();

      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
